// File: rtl/sp_ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// Master indices are sized for the largest supported configuration (8),
// so one index type serves every NUM_MST instance.
package sp_ram_arb_pkg;

    localparam int MAX_MST        = 8;
    localparam int MST_IDX_W      = $clog2(MAX_MST);
    localparam int DATA_WIDTH_DEF = 32;
    localparam int BE_WIDTH       = DATA_WIDTH_DEF / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef logic [MAX_MST-1:0]   mst_vec_t;
    typedef logic [MST_IDX_W-1:0] mst_idx_t;

    typedef struct packed {
        logic     valid;
        mst_idx_t idx;
    } rr_pick_t;

    // Index following idx, wrapping at n masters.
    function automatic mst_idx_t rr_next(input mst_idx_t idx, input int n);
        if (int'(idx) + 1 >= n) return '0;
        return idx + mst_idx_t'(1);
    endfunction

    // First requesting index at or after ptr, wrapping at n masters.
    function automatic rr_pick_t rr_pick(input mst_vec_t req, input mst_idx_t ptr, input int n);
        rr_pick_t pick;
        int       k;
        pick = '0;
        for (int i = 0; i < MAX_MST; i++) begin
            k = (int'(ptr) + i) % n;
            if (i < n && !pick.valid && req[k[MST_IDX_W-1:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = k[MST_IDX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sp_ram_arbiter_rr.sv
// rr_arbiter_core: combinational round-robin pick with a registered
// priority pointer. The pointer moves past each winner unless held, and
// can be loaded directly by the owner of the core.
module rr_arbiter_core
    import sp_ram_arb_pkg::*;
#(
    parameter int NUM_MST = 2
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic [NUM_MST-1:0] req,
    input  logic               hold,
    input  logic               load_en,
    input  mst_idx_t           load_ptr,
    output logic [NUM_MST-1:0] gnt,
    output logic               valid,
    output mst_idx_t           idx
);

    mst_idx_t rr_ptr;
    rr_pick_t pick;

    // Pick the winner and expand it to a one-hot grant.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt   = '0;
        pick  = rr_pick(mst_vec_t'(req), rr_ptr, NUM_MST);
        valid = pick.valid;
        idx   = pick.idx;
        for (int k = 0; k < NUM_MST; k++) begin
            gnt[k] = pick.valid && (int'(pick.idx) == k);
        end
    end

    // Advance the priority pointer past the winner, or load it on request.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (load_en) begin
            rr_ptr <= load_ptr;
        end else if (valid && !hold) begin
            rr_ptr <= rr_next(idx, NUM_MST);
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: shares one single-port RAM (1-cycle read latency) between
// NUM_MST req/gnt/rvalid masters. Round-robin in IDLE; a granted master
// asserting lock keeps exclusive ownership until it drops lock or the lock
// budget of MAX_LOCK cycles runs out.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int NUM_MST    = 2,
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 64
) (
    input  logic                              clk,
    input  logic                              rst_i,
    input  logic [NUM_MST-1:0]                req_i,
    input  logic [NUM_MST-1:0]                lock_i,
    input  logic [NUM_MST-1:0]                we_i,
    input  logic [NUM_MST*(DATA_WIDTH/8)-1:0] be_i,
    input  logic [NUM_MST*ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_MST*DATA_WIDTH-1:0]     wdata_i,
    output logic [NUM_MST-1:0]                gnt_o,
    output logic [NUM_MST-1:0]                rvalid_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              lock_err_o,
    output logic                              ram_en_o,
    output logic [ADDR_WIDTH-1:0]             ram_addr_o,
    output logic [DATA_WIDTH-1:0]             ram_wdata_o,
    output logic                              ram_we_o,
    output logic [DATA_WIDTH/8-1:0]           ram_be_o,
    input  logic [DATA_WIDTH-1:0]             ram_rdata_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

    arb_state_e         state, state_nxt;
    mst_idx_t           owner, owner_nxt;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
    logic               rr_load;
    logic [NUM_MST-1:0] core_gnt;
    logic               core_valid;
    mst_idx_t           core_idx;
    logic               win_valid;
    mst_idx_t           win_idx;
    logic               rsp_pend;
    mst_idx_t           rsp_idx;
    mst_vec_t           req_v, lock_v, we_v;

    assign req_v  = mst_vec_t'(req_i);
    assign lock_v = mst_vec_t'(lock_i);
    assign we_v   = mst_vec_t'(we_i);

    // The pointer already sits at owner+1 from the locking grant; holding it
    // while locked and reloading it on exit keeps that invariant explicit.
    rr_arbiter_core #(.NUM_MST(NUM_MST)) u_rr (
        .clk      (clk),
        .rst_i    (rst_i),
        .req      (req_i),
        .hold     (state == LOCKED),
        .load_en  (rr_load),
        .load_ptr (rr_next(owner, NUM_MST)),
        .gnt      (core_gnt),
        .valid    (core_valid),
        .idx      (core_idx)
    );

    // Lock FSM state register: state, owner and lock budget counter.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state    <= IDLE;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Lock FSM next state: enter on a locking grant, leave on release or budget exhaustion.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        rr_load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (core_valid && lock_v[core_idx]) begin
                    state_nxt    = LOCKED;
                    owner_nxt    = core_idx;
                    lock_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                lock_cnt_nxt = lock_cnt + 1'b1;
                if (!lock_v[owner] || lock_cnt == CNT_LAST) begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                    rr_load      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lock FSM outputs: grant vector, winner selection and timeout pulse.
    always_comb begin
        gnt_o      = '0;
        win_valid  = 1'b0;
        win_idx    = core_idx;
        lock_err_o = 1'b0;
        if (!rst_i) begin
            if (state == IDLE) begin
                gnt_o     = core_gnt;
                win_valid = core_valid;
            end else begin
                win_idx    = owner;
                win_valid  = req_v[owner];
                // A release in the same cycle wins over the timeout.
                lock_err_o = lock_v[owner] && (lock_cnt == CNT_LAST);
                for (int k = 0; k < NUM_MST; k++) begin
                    gnt_o[k] = req_v[owner] && (int'(owner) == k);
                end
            end
        end
    end

    // RAM request mux from the winning master; strobes are quiet without a grant.
    always_comb begin
        ram_en_o    = win_valid;
        ram_addr_o  = addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata_o = wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        ram_we_o    = win_valid && we_v[win_idx];
        ram_be_o    = win_valid ? be_i[int'(win_idx)*BE_W +: BE_W] : '0;
    end

    // Response tracking: fixed 1-cycle latency means one outstanding response at most.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rsp_pend <= 1'b0;
            rsp_idx  <= '0;
        end else begin
            rsp_pend <= win_valid;
            rsp_idx  <= win_idx;
        end
    end

    // One-hot response valid; squashed while reset is asserted.
    always_comb begin
        rvalid_o = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            rvalid_o[k] = !rst_i && rsp_pend && (int'(rsp_idx) == k);
        end
    end

    assign rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Testbench for sp_ram_arbiter: directed scenarios followed by random
// traffic. A cycle-level reference model predicts grants and RAM strobes and
// pushes expected responses into a scoreboard queue; a separate monitor pops
// and compares whenever a response is due.
module tb_sp_ram_arbiter;

    localparam int N        = 2;
    localparam int RAM_SIZE = 32768;
    localparam int AW       = 15;
    localparam int DW       = 32;
    localparam int BW       = DW / 8;
    localparam int MAX_LOCK = 16;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    logic [N-1:0]    req_i, lock_i, we_i;
    logic [N*BW-1:0] be_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [N-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            lock_err_o;
    logic            ram_en_o, ram_we_o;
    logic [AW-1:0]   ram_addr_o;
    logic [DW-1:0]   ram_wdata_o;
    logic [BW-1:0]   ram_be_o;
    logic [DW-1:0]   ram_rdata_i;

    sp_ram_arbiter #(
        .NUM_MST(N), .RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk(clk), .rst_i(rst_i), .req_i(req_i), .lock_i(lock_i),
        .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .lock_err_o(lock_err_o), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_rdata_i(ram_rdata_i)
    );

    // ---------------- RAM wrapper model (environment) ----------------
    logic [DW-1:0] ram_mem [0:RAM_SIZE/4-1];

    always @(posedge clk) begin : ram_env
        logic [DW-1:0] word;
        if (ram_en_o) begin
            word = ram_mem[ram_addr_o[AW-1:2]];
            if (ram_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (ram_be_o[b]) word[8*b +: 8] = ram_wdata_o[8*b +: 8];
                ram_mem[ram_addr_o[AW-1:2]] <= word;
            end else begin
                ram_rdata_i <= word;
            end
        end
    end

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:RAM_SIZE-1];

    typedef struct {
        int            mst;
        bit            rd;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t     sb[$];
    logic [N-1:0] exp_gnt;
    int       m_ptr    = 0;
    bit       m_locked = 1'b0;
    int       m_owner  = 0;
    int       m_left   = 0;   // locked cycles remaining in the budget

    function automatic logic [DW-1:0] ref_read(input int a);
        logic [DW-1:0] v;
        for (int b = 0; b < BW; b++) v[8*b +: 8] = ref_mem[(a & ~3) + b];
        return v;
    endfunction

    // Predict this cycle's grant and RAM strobes, queue the response, then advance.
    always @(negedge clk) begin : model
        int            win;
        logic          err;
        logic [AW-1:0] a;
        rsp_t          r;
        if (rst_i) begin
            exp_gnt = '0;
            check("rst_gnt", gnt_o, 0);
            check("rst_ram_en", ram_en_o, 0);
            check("rst_lock_err", lock_err_o, 0);
            m_ptr    = 0;
            m_locked = 1'b0;
        end else begin
            win = -1;
            err = 1'b0;
            if (!m_locked) begin
                for (int i = 0; i < N; i++)
                    if (win < 0 && req_i[(m_ptr + i) % N]) win = (m_ptr + i) % N;
            end else begin
                if (req_i[m_owner]) win = m_owner;
                err = lock_i[m_owner] && (m_left == 1);
            end
            exp_gnt = '0;
            if (win >= 0) exp_gnt[win] = 1'b1;

            check("gnt", gnt_o, exp_gnt);
            check("ram_en", ram_en_o, (win >= 0));
            check("lock_err", lock_err_o, err);
            if (win >= 0) begin
                a = addr_i[win*AW +: AW];
                check("ram_addr", ram_addr_o, a);
                check("ram_we", ram_we_o, we_i[win]);
                check("ram_be", ram_be_o, be_i[win*BW +: BW]);
                r.mst  = win;
                r.rd   = !we_i[win];
                r.data = '0;
                r.due  = cyc + 1;
                if (we_i[win]) begin
                    check("ram_wdata", ram_wdata_o, wdata_i[win*DW +: DW]);
                    for (int b = 0; b < BW; b++)
                        if (be_i[win*BW + b]) ref_mem[(int'(a) & ~3) + b] = wdata_i[win*DW + 8*b +: 8];
                end else begin
                    r.data = ref_read(int'(a));
                end
                sb.push_back(r);
            end else begin
                check("idle_we", ram_we_o, 0);
                check("idle_be", ram_be_o, 0);
            end

            if (m_locked) begin
                if (!lock_i[m_owner] || m_left == 1) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                end else begin
                    m_left--;
                end
            end else if (win >= 0) begin
                m_ptr = (win + 1) % N;
                if (lock_i[win]) begin
                    m_locked = 1'b1;
                    m_owner  = win;
                    m_left   = MAX_LOCK;
                end
            end
        end
    end

    // Response monitor: pop the response due this cycle and compare.
    always @(negedge clk) begin : monitor
        logic [N-1:0] exp_rv;
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (!rst_i) begin
                exp_rv[sb[0].mst] = 1'b1;
                if (sb[0].rd) check("rdata", rdata_o, sb[0].data);
            end
            void'(sb.pop_front());
        end
        check("rvalid", rvalid_o, exp_rv);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic clr();
        req_i = '0; lock_i = '0; we_i = '0;
        be_i = '0; addr_i = '0; wdata_i = '0;
    endtask

    task automatic set_mst(input int k, input logic r, input logic l, input logic w,
                           input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_i[k] = r; lock_i[k] = l; we_i[k] = w;
        be_i[k*BW +: BW] = b; addr_i[k*AW +: AW] = a; wdata_i[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clr();
        step();
        rst_i = 1'b0;
    endtask

    task automatic put_word(input int a, input logic [DW-1:0] v);
        ram_mem[a / 4] = v;
        for (int b = 0; b < BW; b++) ref_mem[(a & ~3) + b] = v[8*b +: 8];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: still running at cycle %0d, expected finish long before", cyc);
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        clr();
        for (int w = 0; w < RAM_SIZE / 4; w++)
            put_word(4 * w, (w < 64) ? ((32'h0101_0101 * w) ^ 32'h5A00_00A5) : '0);
        put_word('h10, 32'hDEAD_BEEF);
        put_word('h20, 32'h1122_3344);

        // Reset state
        at_neg();
        check("reset_gnt", gnt_o, 0);
        check("reset_rvalid", rvalid_o, 0);
        check("reset_ram_en", ram_en_o, 0);
        step();
        step();
        rst_i = 1'b0;

        // Single uncontended read
        set_mst(0, 1, 0, 0, '1, 'h10, '0);
        at_neg();
        check("t1_gnt", gnt_o, 2'b01);
        check("t1_addr", ram_addr_o, 'h10);
        step();
        clr();
        at_neg();
        check("t1_rvalid", rvalid_o, 2'b01);
        check("t1_rdata", rdata_o, 32'hDEAD_BEEF);
        step();

        // Continuous contention alternates after reset
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_mst(0, 1, 0, 0, '1, 'h10, '0);
            set_mst(1, 1, 0, 0, '1, 'h20, '0);
            at_neg();
            check("t2_gnt", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) check("t2_rvalid", rvalid_o, (i % 2 == 1) ? 2'b01 : 2'b10);
            step();
        end
        clr();
        step();

        // Partial write then read-back
        set_mst(1, 1, 0, 1, 4'b0011, 'h20, 32'hCAFE_F00D);
        at_neg();
        check("t3_wr_gnt", gnt_o, 2'b10);
        step();
        clr();
        set_mst(0, 1, 0, 0, '1, 'h20, '0);
        at_neg();
        check("t3_rd_gnt", gnt_o, 2'b01);
        step();
        clr();
        at_neg();
        check("t3_rdata", rdata_o, 32'h1122_F00D);
        step();

        // Master 1 locks for 5 cycles, master 0 starved until release
        for (int i = 0; i < 5; i++) begin
            set_mst(1, 1, 1, 0, '1, 'h30, '0);
            set_mst(0, 1, 0, 0, '1, 'h40, '0);
            at_neg();
            check("t4_locked_gnt", gnt_o, 2'b10);
            step();
        end
        set_mst(1, 0, 0, 0, '0, '0, '0);
        at_neg();
        check("t4_release_gnt", gnt_o, 2'b00);
        step();
        at_neg();
        check("t4_after_gnt", gnt_o, 2'b01);
        step();
        clr();

        // Lock timeout
        do_reset();
        for (int i = 0; i < MAX_LOCK + 2; i++) begin
            set_mst(0, 1, 1, 0, '1, 'h50, '0);
            set_mst(1, 1, 0, 0, '1, 'h60, '0);
            at_neg();
            check("t5_lock_err", lock_err_o, (i == MAX_LOCK));
            check("t5_gnt", gnt_o, (i <= MAX_LOCK) ? 2'b01 : 2'b10);
            step();
        end
        clr();
        step();

        // Reset right after a read grant squashes the response
        set_mst(0, 1, 0, 0, '1, 'h10, '0);
        at_neg();
        check("t6_gnt", gnt_o, 2'b01);
        step();
        rst_i = 1'b1;
        set_mst(0, 1, 0, 0, '1, 'h10, '0);
        set_mst(1, 1, 0, 0, '1, 'h20, '0);
        at_neg();
        check("t6_squash", rvalid_o, 2'b00);
        step();
        rst_i = 1'b0;
        at_neg();
        check("t6_post_rst_gnt", gnt_o, 2'b01);
        step();
        clr();
        step();

        // Random traffic honouring the hold-until-grant rule
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!(req_i[k] && !exp_gnt[k])) begin
                    set_mst(k, ($urandom_range(0, 99) < 60), lock_i[k], $urandom_range(0, 1),
                            BW'($urandom), AW'($urandom_range(0, 255)), $urandom);
                end
                lock_i[k] = lock_i[k] ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 15);
            end
            rst_i = ($urandom_range(0, 199) == 0);
            step();
        end

        rst_i = 1'b0;
        clr();
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Shares one single-port data RAM between NUM_MST requesters, e.g. core data port, PQC accelerator and debug/loader.
- Requester side uses the req/gnt/rvalid handshake. RAM side drives en/addr/wdata/we/be with a fixed 1-cycle read latency.
- Round-robin arbitration, with an optional per-master lock for atomic multi-access sequences (bounded by a timeout).
- Sits between the bus masters and the single-port RAM wrapper.

Parameters:
- NUM_MST, 2, number of requesters (2..8).
- RAM_SIZE, 32768, RAM size in bytes.
- ADDR_WIDTH, $clog2(RAM_SIZE), byte address width.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 wide.
- MAX_LOCK, 64, maximum consecutive locked cycles before forced release.

Ports:
- clk  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_i  in  NUM_MST  per-master access request
- lock_i  in  NUM_MST  per-master request to hold ownership after grant
- we_i  in  NUM_MST  write enable per master
- be_i  in  NUM_MST*DATA_WIDTH/8  byte enables, packed by master
- addr_i  in  NUM_MST*ADDR_WIDTH  byte addresses, packed
- wdata_i  in  NUM_MST*DATA_WIDTH  write data, packed
- gnt_o  in/out: out  NUM_MST  one-hot grant, same cycle as request
- rvalid_o  out  NUM_MST  one-hot response valid, cycle after grant (reads and writes)
- rdata_o  out  DATA_WIDTH  read data, shared by all masters
- lock_err_o  out  1  one-cycle pulse on lock timeout
- ram_en_o  out  1  RAM enable
- ram_addr_o  out  ADDR_WIDTH  RAM byte address
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_en_o

Behaviour:
- **Reset:** clock is clk; reset is rst_i, synchronous and active-high. On reset:
  - state=IDLE, rr_ptr=0, lock_cnt=0, rsp_idx=0, rsp_pend=0.
  - gnt_o=0, rvalid_o=0, lock_err_o=0, ram_en_o=0.
  - rdata_o=ram_rdata_i pass-through; its value is don't-care while no rvalid_o is high.
- **Grant:** combinational, 0 wait states when uncontended.
  - gnt_o[k]=1 iff req_i[k] and k is the winner.
  - ram_en_o = |gnt_o. ram_addr_o, ram_wdata_o, ram_we_o and ram_be_o are muxed from the winner.
  - With no grant, ram_we_o=0 and ram_be_o=0.
- **Round-robin (IDLE):**
  - Winner is the first requesting index at or after rr_ptr, with wrap-around.
  - After a grant to k, rr_ptr <= (k+1) mod NUM_MST.
  - rr_ptr is unchanged when no grant is issued.
- **Response:**
  - rsp_pend <= |gnt_o; rsp_idx <= winner index.
  - rvalid_o[rsp_idx] = rsp_pend, exactly 1 cycle after gnt.
  - Back-to-back grants give back-to-back rvalids. No response queue is needed; fixed latency 1 means at most 1 response is outstanding.
- **State machine:**
  - IDLE -> LOCKED when the granted master k has lock_i[k]=1. Record owner=k, lock_cnt=0.
  - LOCKED: only owner may be granted; all other masters see gnt=0. lock_cnt increments every cycle.
  - LOCKED -> IDLE when lock_i[owner]=0 in a cycle. The access in that cycle, if any, is still granted to the owner.
  - LOCKED -> IDLE when lock_cnt reaches MAX_LOCK-1. lock_err_o pulses 1 cycle and rr_ptr <= owner+1.
  - A lock only takes effect when accompanied by a granted request; lock_i without req_i in IDLE is ignored.
- **Simultaneous events:**
  - All masters requesting: fair rotation, each served once per NUM_MST grants.
  - Lock release and timeout in the same cycle: treated as a normal release, no lock_err_o.
- **Reset mid-operation:** a pending rvalid is squashed (rvalid_o=0 the next cycle) and lock ownership is dropped.
- **Requester rules:** a master must keep req and its payload stable until gnt. The arbiter never grants a master with req_i=0.
- **Address:** passed through at full byte width. Word alignment is the RAM wrapper's concern.

Decomposition:
- Shared package sp_ram_arb_pkg:
  - arb_state_e {IDLE, LOCKED}.
  - Function rr_pick(req, ptr) returning the winner index and valid.
  - Localparams MST_IDX_W=$clog2(NUM_MST) and BE_WIDTH.
- One natural sub-module, rr_arbiter_core: combinational round-robin pick plus registered rr_ptr, reusable elsewhere.
- Lock FSM, response tracking and muxing remain in sp_ram_arbiter.

Test Plan:
- Single master 0 reads addr 0x10 with RAM preloaded 0xDEADBEEF -> gnt_o=01 the same cycle, ram_addr_o=0x10, rvalid_o=01 the next cycle with rdata_o=0xDEADBEEF.
- Both masters request continuously for 6 cycles after reset -> grants alternate 01,10,01,10,01,10; rvalid_o follows one cycle later each time.
- Master 1 write 0xCAFEF00D with be=4'b0011 at 0x20, then master 0 reads 0x20 (old value 0x11223344) -> rdata_o=0x1122F00D.
- Master 1 asserts lock with req for 5 cycles while master 0 requests constantly -> gnt_o=10 for all 5 cycles, master 0 starved. After lock drop, master 0 is granted the next cycle.
- Master 0 holds lock for MAX_LOCK+2 cycles with master 1 requesting -> lock_err_o pulses at cycle MAX_LOCK-1, master 1 is granted the following cycle.
- Reset asserted the cycle after a read grant -> rvalid_o stays 0, and the first post-reset grant goes to master 0 with rr_ptr=0.
